// File: rtl/prio_seg_scan.sv
// Priority encoder over a request vector. The captured MSB index is shown on a
// multiplexed active-low 7-segment display, in decimal or hexadecimal.
module prio_seg_scan #(
  parameter int unsigned IN_W     = 8,
  parameter int unsigned NDIGITS  = 2,
  parameter int unsigned SCAN_DIV = 1000,
  localparam int unsigned IW      = (IN_W > 1) ? $clog2(IN_W) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_W-1:0]    in_bits,
  input  logic               sample,
  input  logic               hex_mode,
  output logic [IW-1:0]      idx,
  output logic               valid,
  output logic [6:0]         seg,
  output logic [NDIGITS-1:0] an
);

  localparam int unsigned PW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // Integer power, used to build per-digit divisors at elaboration time.
  function automatic int unsigned pow_u(input int unsigned b, input int unsigned e);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  // Hex nibble to active-low segment pattern (bit6 = a ... bit0 = g).
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  logic [IW-1:0]      idx_q,   idx_d;
  logic               valid_q, valid_d;
  logic               hex_q,   hex_d;
  logic [31:0]        cnt_q,   cnt_d;
  logic [PW-1:0]      ptr_q,   ptr_d;
  logic [6:0]         seg_q,   seg_d;
  logic [NDIGITS-1:0] an_q,    an_d;

  logic [IW-1:0]             msb_idx;
  logic [31:0]               idx_ext;
  logic [NDIGITS-1:0][3:0]   dig_val;
  logic [NDIGITS-1:0]        dig_blank;
  logic [3:0]                cur_val;
  logic                      cur_blank;
  logic                      wrap;

  // Index of the most-significant set request bit; zero when none are set.
  always_comb begin
    msb_idx = '0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (in_bits[i]) msb_idx = IW'(i);
    end
  end

  assign idx_ext = 32'(idx_q);

  // Per-digit value and leading-zero blanking for both radices.
  for (genvar k = 0; k < NDIGITS; k++) begin : g_dig
    localparam int unsigned P10 = pow_u(10, k);
    localparam int unsigned P16 = pow_u(16, k);
    logic [3:0] dec_v;
    logic [3:0] hex_v;
    assign dec_v = 4'((idx_ext / P10) % 32'd10);
    assign hex_v = 4'((idx_ext / P16) % 32'd16);
    assign dig_val[k] = hex_q ? hex_v : dec_v;
    if (k == 0) begin : g_lsd
      assign dig_blank[k] = 1'b0;
    end else begin : g_upper
      assign dig_blank[k] = idx_ext < (hex_q ? P16 : P10);
    end
  end

  // Select the digit addressed by the scan pointer.
  always_comb begin
    cur_val   = '0;
    cur_blank = 1'b0;
    for (int unsigned k = 0; k < NDIGITS; k++) begin
      if (ptr_q == PW'(k)) begin
        cur_val   = dig_val[k];
        cur_blank = dig_blank[k];
      end
    end
  end

  // Next-state: capture on sample, scan counter/pointer, display registers.
  always_comb begin
    idx_d   = idx_q;
    valid_d = valid_q;
    hex_d   = hex_q;
    cnt_d   = cnt_q + 32'd1;
    ptr_d   = ptr_q;
    wrap    = 1'b0;

    if (sample) begin
      idx_d   = msb_idx;
      valid_d = |in_bits;
      hex_d   = hex_mode;
    end

    if (cnt_q == 32'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      wrap  = 1'b1;
    end

    if (wrap) begin
      ptr_d = (ptr_q == PW'(NDIGITS - 1)) ? '0 : ptr_q + PW'(1);
    end

    an_d = ~(NDIGITS'(1) << ptr_q);

    if (!valid_q)       seg_d = SEG_DASH;
    else if (cur_blank) seg_d = SEG_BLANK;
    else                seg_d = glyph(cur_val);
  end

  // State registers with synchronous reset taking priority over sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      hex_q   <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= '1;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
      hex_q   <= hex_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign idx   = idx_q;
  assign valid = valid_q;
  assign seg   = seg_q;
  assign an    = an_q;

endmodule

// File: tb/tb_prio_seg_scan.sv
// Directed bench for prio_seg_scan: 8-bit and 16-bit instances, SCAN_DIV=4.
module tb_prio_seg_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       sample = 1'b0;
  logic       hex_mode = 1'b0;
  logic [7:0] in_bits = '0;
  logic [2:0] idx;
  logic       valid;
  logic [6:0] seg;
  logic [1:0] an;

  logic        sample16 = 1'b0;
  logic        hex16 = 1'b0;
  logic [15:0] in16 = '0;
  logic [3:0]  idx16;
  logic        valid16;
  logic [6:0]  seg16;
  logic [1:0]  an16;

  int total = 0;
  int bad = 0;

  prio_seg_scan #(.IN_W(8), .NDIGITS(2), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .in_bits(in_bits), .sample(sample), .hex_mode(hex_mode),
    .idx(idx), .valid(valid), .seg(seg), .an(an)
  );

  prio_seg_scan #(.IN_W(16), .NDIGITS(2), .SCAN_DIV(4)) dut16 (
    .clk(clk), .rst(rst), .in_bits(in16), .sample(sample16), .hex_mode(hex16),
    .idx(idx16), .valid(valid16), .seg(seg16), .an(an16)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  // Reset state, with a simultaneous sample that must be ignored.
  task automatic test_reset();
    rst = 1'b1; sample = 1'b1; in_bits = 8'hFF;
    step(1);
    total++; if (idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", idx); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (seg !== 7'b1111111) begin bad++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
    total++; if (an !== 2'b11) begin bad++; $display("FAIL reset_an got=%b exp=11", an); end
    rst = 1'b0; sample = 1'b0; in_bits = '0;
  endtask

  // Digit enables after reset: 10 x4, 01 x4, 10 again; dashes while invalid.
  task automatic test_scan_timing();
    logic [1:0] exp_an;
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      step(1);
      exp_an = (((i - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01;
      total++; if (an !== exp_an) begin bad++; $display("FAIL scan_an cyc=%0d got=%b exp=%b", i, an, exp_an); end
      total++; if (seg !== 7'b1111110) begin bad++; $display("FAIL scan_seg cyc=%0d got=%b exp=1111110", i, seg); end
    end
  endtask

  // Sample 00100110: idx 5, digit0 '5', digit1 blank; sample leaves scan phase alone.
  task automatic test_basic();
    do_reset();
    sample = 1'b1; in_bits = 8'b00100110; hex_mode = 1'b0;
    step(1);
    sample = 1'b0; in_bits = '0;
    total++; if (idx !== 3'd5) begin bad++; $display("FAIL basic_idx got=%0d exp=5", idx); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", valid); end
    step(1);
    total++; if (an !== 2'b10) begin bad++; $display("FAIL basic_an0 got=%b exp=10", an); end
    total++; if (seg !== 7'b0100100) begin bad++; $display("FAIL basic_d0 got=%b exp=0100100", seg); end
    step(3);
    total++; if (an !== 2'b01) begin bad++; $display("FAIL basic_an1 got=%b exp=01", an); end
    total++; if (seg !== 7'b1111111) begin bad++; $display("FAIL basic_d1 got=%b exp=1111111", seg); end
    step(4);
    total++; if (an !== 2'b10) begin bad++; $display("FAIL basic_an0b got=%b exp=10", an); end
    total++; if (seg !== 7'b0100100) begin bad++; $display("FAIL basic_d0b got=%b exp=0100100", seg); end
    total++; if (idx !== 3'd5) begin bad++; $display("FAIL basic_hold got=%0d exp=5", idx); end
  endtask

  // Zero vector clears valid and idx; both digits show dashes.
  task automatic test_zero();
    do_reset();
    sample = 1'b1; in_bits = 8'h80;
    step(1);
    total++; if (idx !== 3'd7) begin bad++; $display("FAIL zero_pre_idx got=%0d exp=7", idx); end
    in_bits = 8'h00;
    step(1);
    sample = 1'b0;
    total++; if (idx !== 3'd0) begin bad++; $display("FAIL zero_idx got=%0d exp=0", idx); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL zero_valid got=%b exp=0", valid); end
    step(1);
    total++; if (seg !== 7'b1111110) begin bad++; $display("FAIL zero_d0 got=%b exp=1111110", seg); end
    step(2);
    total++; if (an !== 2'b01) begin bad++; $display("FAIL zero_an1 got=%b exp=01", an); end
    total++; if (seg !== 7'b1111110) begin bad++; $display("FAIL zero_d1 got=%b exp=1111110", seg); end
  endtask

  // Consecutive samples each take effect; display follows with one cycle lag.
  task automatic test_back_to_back();
    do_reset();
    sample = 1'b1; in_bits = 8'h01;
    step(1);
    total++; if (idx !== 3'd0 || valid !== 1'b1) begin bad++; $display("FAIL b2b_1 idx=%0d valid=%b exp=0/1", idx, valid); end
    in_bits = 8'h40;
    step(1);
    total++; if (idx !== 3'd6) begin bad++; $display("FAIL b2b_2 idx=%0d exp=6", idx); end
    total++; if (seg !== 7'b0000001) begin bad++; $display("FAIL b2b_seg0 got=%b exp=0000001", seg); end
    in_bits = 8'h03;
    step(1);
    total++; if (idx !== 3'd1) begin bad++; $display("FAIL b2b_3 idx=%0d exp=1", idx); end
    total++; if (seg !== 7'b0100000) begin bad++; $display("FAIL b2b_seg6 got=%b exp=0100000", seg); end
    sample = 1'b0; in_bits = 8'hFF;
    step(1);
    total++; if (seg !== 7'b1001111) begin bad++; $display("FAIL b2b_seg1 got=%b exp=1001111", seg); end
    total++; if (idx !== 3'd1) begin bad++; $display("FAIL b2b_hold idx=%0d exp=1", idx); end
    in_bits = '0;
  endtask

  // 16-bit instance: 0x1000 in decimal ("12") and hex ("C"); radix holds between samples.
  task automatic test_radix16();
    do_reset();
    sample16 = 1'b1; in16 = 16'h1000; hex16 = 1'b0;
    step(1);
    sample16 = 1'b0;
    total++; if (idx16 !== 4'd12) begin bad++; $display("FAIL r16_idx got=%0d exp=12", idx16); end
    step(1);
    total++; if (seg16 !== 7'b0010010) begin bad++; $display("FAIL r16_dec_d0 got=%b exp=0010010", seg16); end
    step(3);
    total++; if (an16 !== 2'b01) begin bad++; $display("FAIL r16_dec_an got=%b exp=01", an16); end
    total++; if (seg16 !== 7'b1001111) begin bad++; $display("FAIL r16_dec_d1 got=%b exp=1001111", seg16); end

    do_reset();
    sample16 = 1'b1; hex16 = 1'b1;
    step(1);
    sample16 = 1'b0; hex16 = 1'b0;
    step(1);
    total++; if (seg16 !== 7'b0110001) begin bad++; $display("FAIL r16_hex_d0 got=%b exp=0110001", seg16); end
    step(3);
    total++; if (seg16 !== 7'b1111111) begin bad++; $display("FAIL r16_hex_d1 got=%b exp=1111111", seg16); end

    do_reset();
    sample16 = 1'b1; in16 = 16'h8000; hex16 = 1'b1;
    step(1);
    sample16 = 1'b0; in16 = '0;
    step(1);
    total++; if (seg16 !== 7'b0111000) begin bad++; $display("FAIL r16_hexF got=%b exp=0111000", seg16); end
  endtask

  // Sample on the wrap edge, then reset while ptr=1; rst beats sample; scan restarts at digit 0.
  task automatic test_wrap_reset();
    do_reset();
    step(3);
    sample = 1'b1; in_bits = 8'b00100110;
    step(1);
    sample = 1'b0; in_bits = '0;
    total++; if (an !== 2'b10 || seg !== 7'b1111110) begin bad++; $display("FAIL wrap_pre an=%b seg=%b exp=10/1111110", an, seg); end
    step(1);
    total++; if (an !== 2'b01) begin bad++; $display("FAIL wrap_an got=%b exp=01", an); end
    total++; if (seg !== 7'b1111111) begin bad++; $display("FAIL wrap_seg got=%b exp=1111111", seg); end
    rst = 1'b1; sample = 1'b1; in_bits = 8'hFF;
    step(1);
    rst = 1'b0; sample = 1'b0; in_bits = '0;
    total++; if (idx !== 3'd0 || valid !== 1'b0) begin bad++; $display("FAIL wrst_iv idx=%0d valid=%b exp=0/0", idx, valid); end
    total++; if (seg !== 7'b1111111 || an !== 2'b11) begin bad++; $display("FAIL wrst_disp seg=%b an=%b exp=1111111/11", seg, an); end
    step(1);
    total++; if (an !== 2'b10 || seg !== 7'b1111110) begin bad++; $display("FAIL wrst_first seg=%b an=%b exp=1111110/10", seg, an); end
    step(3);
    total++; if (an !== 2'b10) begin bad++; $display("FAIL wrst_hold an=%b exp=10", an); end
    step(1);
    total++; if (an !== 2'b01) begin bad++; $display("FAIL wrst_adv an=%b exp=01", an); end
  endtask

  initial begin
    test_reset();
    test_scan_timing();
    test_basic();
    test_zero();
    test_back_to_back();
    test_radix16();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
